// File: rtl/clk_div_pkg.sv
// Shared widths and reset values for the clock divider.
package clk_div_pkg;

    localparam int unsigned SCALE_W = 32;
    localparam int unsigned LED_W   = 5;

    localparam logic        ClkOutRst = 1'b0;
    localparam int unsigned CntRst    = 0;
    localparam int unsigned LedRst    = 0;

endpackage

// File: rtl/clk_div_counter.sv
// Terminal-count counter: wraps at scale-1 and emits a one-cycle tick on the wrapping edge.
module clk_div_counter #(
    parameter int unsigned SCALE_W = clk_div_pkg::SCALE_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [SCALE_W-1:0] scale,
    output logic               tick
);
    import clk_div_pkg::*;

    localparam logic [SCALE_W-1:0] One = SCALE_W'(1);

    logic [SCALE_W-1:0] cnt_q, cnt_d;
    logic [SCALE_W-1:0] limit;

    // >= rather than == so a mid-period drop in scale wraps on the next edge.
    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        limit = '0;
        if (scale == '0) begin
            cnt_d = '0;
        end else begin
            limit = scale - One;
            if (cnt_q >= limit) begin
                cnt_d = '0;
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q + One;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= SCALE_W'(CntRst);
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/clk_div.sv
// Clock divider: clk_out toggles every scale clk cycles; led counts clk_out rising edges.
module clk_div #(
    parameter int unsigned SCALE_W = clk_div_pkg::SCALE_W,
    parameter int unsigned LED_W   = clk_div_pkg::LED_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [SCALE_W-1:0] scale,
    output logic               clk_out,
    output logic [LED_W-1:0]   led
);
    import clk_div_pkg::*;

    logic             tick;
    logic             clk_out_q, clk_out_d;
    logic [LED_W-1:0] led_q, led_d;

    clk_div_counter #(
        .SCALE_W (SCALE_W)
    ) u_counter (
        .clk   (clk),
        .reset (reset),
        .scale (scale),
        .tick  (tick)
    );

    // A zero scale parks clk_out low but leaves the edge count alone.
    always_comb begin
        clk_out_d = clk_out_q;
        led_d     = led_q;
        if (scale == '0) begin
            clk_out_d = 1'b0;
        end else if (tick) begin
            clk_out_d = ~clk_out_q;
            if (!clk_out_q) begin
                led_d = led_q + LED_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_out_q <= ClkOutRst;
            led_q     <= LED_W'(LedRst);
        end else begin
            clk_out_q <= clk_out_d;
            led_q     <= led_d;
        end
    end

    assign clk_out = clk_out_q;
    assign led     = led_q;

endmodule

// File: tb/tb_clk_div.sv
// Directed bench for clk_div: expected toggles are queued as stimulus is applied.
module tb_clk_div;

    localparam int unsigned SW = 32;
    localparam int unsigned LW = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [SW-1:0] scale;
    logic          clk_out;
    logic [LW-1:0] led;

    typedef struct {
        logic          lvl;
        int unsigned   cycles;
        logic [LW-1:0] led;
    } exp_t;

    exp_t          sb[$];
    int unsigned   checks = 0;
    int unsigned   errors = 0;
    logic          exp_lvl;
    logic [LW-1:0] exp_led;

    always #5 clk = ~clk;

    clk_div #(
        .SCALE_W (SW),
        .LED_W   (LW)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .scale   (scale),
        .clk_out (clk_out),
        .led     (led)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Model the next clk_out transition: it lands cyc edges after the previous one.
    task automatic push_next(input int unsigned cyc);
        exp_t e;
        exp_lvl = ~exp_lvl;
        if (exp_lvl) exp_led = exp_led + LW'(1);
        e.lvl    = exp_lvl;
        e.cycles = cyc;
        e.led    = exp_led;
        sb.push_back(e);
    endtask

    task automatic wait_toggle(input string tag);
        logic        prev;
        int unsigned n;
        exp_t        e;
        prev = clk_out;
        n    = 0;
        while (clk_out === prev && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() == 0) begin
            check({tag, " queue"}, 64'(sb.size()), 64'd1);
        end else begin
            e = sb.pop_front();
            check({tag, " cycles"}, 64'(n), 64'(e.cycles));
            check({tag, " level"}, 64'(clk_out), 64'(e.lvl));
            check({tag, " led"}, 64'(led), 64'(e.led));
        end
    endtask

    initial begin
        int unsigned s;
        scale   = SW'(1000);
        reset   = 1'b0;
        exp_lvl = 1'b0;
        exp_led = '0;

        // Reset state, then 50 kHz operation with scale = 1000.
        repeat (3) @(negedge clk);
        check("rst clk_out", 64'(clk_out), 64'd0);
        check("rst led", 64'(led), 64'd0);
        check("rst cnt", 64'(dut.u_counter.cnt_q), 64'd0);
        reset = 1'b1;
        push_next(1000);
        push_next(1000);
        push_next(1000);
        wait_toggle("s1000 rise1");
        wait_toggle("s1000 fall1");
        wait_toggle("s1000 rise2");

        // Shrink scale mid-period: toggle on the very next edge.
        repeat (600) @(negedge clk);
        check("mid cnt", 64'(dut.u_counter.cnt_q), 64'd600);
        scale = SW'(10);
        push_next(1);
        wait_toggle("shrink toggle");
        push_next(10);
        wait_toggle("shrink rise");

        // scale = 0 forces clk_out low and freezes led.
        repeat (3) @(negedge clk);
        scale = '0;
        @(negedge clk);
        check("zero force", 64'(clk_out), 64'd0);
        exp_lvl = 1'b0;
        repeat (99) @(negedge clk);
        check("zero clk_out", 64'(clk_out), 64'd0);
        check("zero cnt", 64'(dut.u_counter.cnt_q), 64'd0);
        check("zero led", 64'(led), 64'(exp_led));
        scale = SW'(4);
        push_next(4);
        wait_toggle("s4 rise");
        push_next(4);
        wait_toggle("s4 fall");
        push_next(4);
        wait_toggle("s4 rise2");

        // Short asynchronous reset pulse between edges mid-period.
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("async clk_out", 64'(clk_out), 64'd0);
        check("async led", 64'(led), 64'd0);
        check("async cnt", 64'(dut.u_counter.cnt_q), 64'd0);
        #1 reset = 1'b1;
        exp_lvl = 1'b0;
        exp_led = '0;
        push_next(4);
        wait_toggle("after release");

        // scale = 1: clk/2, led wraps after 32 rises.
        scale = SW'(1);
        for (int i = 0; i < 64; i++) begin
            push_next(1);
            wait_toggle("s1");
        end

        // Random scale changed only at toggle boundaries.
        for (int i = 0; i < 20; i++) begin
            s     = $urandom_range(64, 1);
            scale = SW'(s);
            push_next(s);
            wait_toggle("rand");
        end

        check("sb drained", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
